// File: rtl/cpu_axi_pkg.sv
// Shared constants, FSM state types and the AR request record for the
// core-to-AXI bridge.
package cpu_axi_pkg;

   localparam logic [3:0] INST_ID = 4'd0;
   localparam logic [3:0] DATA_ID = 4'd1;

   localparam logic [2:0] SIZE_BYTE = 3'd0;
   localparam logic [2:0] SIZE_HALF = 3'd1;
   localparam logic [2:0] SIZE_WORD = 3'd2;

   typedef enum logic       {AR_IDLE, AR_BUSY} ar_state_t;
   typedef enum logic       {I_IDLE, I_WAIT} i_state_t;
   typedef enum logic [1:0] {D_IDLE, D_RD, D_WR, D_WR_B} d_state_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
   } ar_req_t;

   // Core size field to AXI size; the top bit of the core field is dropped.
   function automatic logic [2:0] axi_size(input logic [1:0] s);
      case (s)
         2'd0:    return SIZE_BYTE;
         2'd1:    return SIZE_HALF;
         2'd2:    return SIZE_WORD;
         default: return {1'b0, s};
      endcase
   endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// AXI master bus as seen by the bridge; constant fields are tied off outside.
interface cpu_axi_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arvalid, rready,
      output awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rid, rdata, rlast, rvalid, awready, wready, bvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arvalid, rready,
      input  awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rid, rdata, rlast, rvalid, awready, wready, bvalid
   );
endinterface

// File: rtl/axi_wr_ctrl.sv
// Single-beat write engine: AW and W valids are raised together and each
// drops on its own handshake; wr_done flags the B response that ends it.
module axi_wr_ctrl
   import cpu_axi_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        wr_phase,
   input  logic        b_phase,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [3:0]  req_wstrb,
   input  logic [31:0] req_wdata,
   input  logic        awready,
   input  logic        wready,
   input  logic        bvalid,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   output logic        aw_w_done,
   output logic        wr_done
);
   logic aw_done, w_done, aw_hs, w_hs;

   assign aw_hs     = awvalid & awready;
   assign w_hs      = wvalid & wready;
   // Both address and data accepted, counting handshakes in this cycle.
   assign aw_w_done = wr_phase & (aw_done | aw_hs) & (w_done | w_hs);
   // A B arriving with the last AW/W handshake completes the write too.
   assign wr_done   = bvalid & (b_phase | aw_w_done);

   // Latch the write on accept, then retire AW and W independently.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         awaddr  <= '0;
         awsize  <= '0;
         awvalid <= 1'b0;
         wdata   <= '0;
         wstrb   <= '0;
         wvalid  <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else if (start) begin
         awaddr  <= req_addr;
         awsize  <= axi_size(req_size);
         awvalid <= 1'b1;
         wdata   <= req_wdata;
         wstrb   <= req_wstrb;
         wvalid  <= 1'b1;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
         end
         if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/cpu_axi_bridge.sv
// Merges the core's instruction and data SRAM-like ports onto one AXI master.
// Fetches are INCR bursts, data accesses single beats; one outstanding
// transaction per side, reads separated by ID.
module cpu_axi_bridge
   import cpu_axi_pkg::*;
#(
   parameter int         INST_BURST_LEN = 4,
   parameter logic [3:0] INST_ARID      = INST_ID,
   parameter logic [3:0] DATA_ARID      = DATA_ID
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req,
   input  logic [2:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_rdy,
   output logic        inst_sram_valid,
   output logic        inst_sram_last,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [2:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addrok,
   output logic        data_sram_dataok,
   output logic [31:0] data_sram_rdata,
   cpu_axi_bridge_if.master axi
);
   ar_state_t   ar_state;
   i_state_t    i_state;
   d_state_t    d_state;
   ar_req_t     ar_q;
   logic        arvalid_q;
   logic        ar_free, d_rd_elig, i_elig, d_rd_take, i_take, d_wr_take;
   logic        r_inst, r_data, aw_w_done, wr_done;
   logic [31:0] awaddr, wdata;
   logic [2:0]  awsize;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid;
   logic        unused_ok;

   // Fetch size is fixed at word; only the low size bits matter for data.
   assign unused_ok = &{1'b0, inst_sram_size, data_sram_size[2]};

   // The AR register may be reloaded in the cycle its current request is
   // accepted, so a losing fetch follows a data read without a dead cycle.
   assign ar_free   = (ar_state == AR_IDLE) | axi.arready;
   assign d_rd_elig = data_sram_req & ~data_sram_wr & (d_state == D_IDLE);
   assign i_elig    = inst_sram_req & (i_state == I_IDLE);
   assign d_rd_take = ar_free & d_rd_elig;
   assign i_take    = ar_free & i_elig & ~d_rd_elig;
   assign d_wr_take = data_sram_req & data_sram_wr & (d_state == D_IDLE);
   assign r_inst    = axi.rvalid & (axi.rid == INST_ARID) & (i_state == I_WAIT);
   assign r_data    = axi.rvalid & (axi.rid == DATA_ARID) & (d_state == D_RD);

   assign inst_sram_rdy    = i_take;
   assign inst_sram_valid  = r_inst;
   assign inst_sram_last   = r_inst & axi.rlast;
   assign inst_sram_rdata  = axi.rdata;
   assign data_sram_addrok = d_rd_take | d_wr_take;
   assign data_sram_dataok = r_data | wr_done;
   assign data_sram_rdata  = axi.rdata;

   assign axi.arid    = ar_q.id;
   assign axi.araddr  = ar_q.addr;
   assign axi.arlen   = ar_q.len;
   assign axi.arsize  = ar_q.size;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = 1'b1;
   assign axi.awaddr  = awaddr;
   assign axi.awsize  = awsize;
   assign axi.awvalid = awvalid;
   assign axi.wdata   = wdata;
   assign axi.wstrb   = wstrb;
   assign axi.wvalid  = wvalid;
   assign axi.bready  = 1'b1;

   // AR register: load the winning read, hold it until arready.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ar_state  <= AR_IDLE;
         ar_q      <= '0;
         arvalid_q <= 1'b0;
      end else if (d_rd_take) begin
         ar_state  <= AR_BUSY;
         ar_q      <= '{id: DATA_ARID, addr: data_sram_addr, len: 8'd0,
                        size: axi_size(data_sram_size[1:0])};
         arvalid_q <= 1'b1;
      end else if (i_take) begin
         ar_state  <= AR_BUSY;
         ar_q      <= '{id: INST_ARID, addr: inst_sram_addr,
                        len: 8'(INST_BURST_LEN - 1), size: SIZE_WORD};
         arvalid_q <= 1'b1;
      end else if (ar_state == AR_BUSY && axi.arready) begin
         ar_state  <= AR_IDLE;
         arvalid_q <= 1'b0;
      end
   end

   // Instruction side: one burst in flight, closed by rlast.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_state <= I_IDLE;
      end else begin
         case (i_state)
            I_IDLE:  if (i_take) i_state <= I_WAIT;
            I_WAIT:  if (r_inst && axi.rlast) i_state <= I_IDLE;
            default: i_state <= I_IDLE;
         endcase
      end
   end

   // Data side: one read or write in flight, closed by its dataok.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         d_state <= D_IDLE;
      end else begin
         case (d_state)
            D_IDLE: begin
               if (d_rd_take)      d_state <= D_RD;
               else if (d_wr_take) d_state <= D_WR;
            end
            D_RD:    if (r_data) d_state <= D_IDLE;
            D_WR: begin
               if (wr_done)        d_state <= D_IDLE;
               else if (aw_w_done) d_state <= D_WR_B;
            end
            D_WR_B:  if (wr_done) d_state <= D_IDLE;
            default: d_state <= D_IDLE;
         endcase
      end
   end

   axi_wr_ctrl u_wr (
      .clk       (clk),
      .resetn    (resetn),
      .start     (d_wr_take),
      .wr_phase  (d_state == D_WR),
      .b_phase   (d_state == D_WR_B),
      .req_addr  (data_sram_addr),
      .req_size  (data_sram_size[1:0]),
      .req_wstrb (data_sram_wstrb),
      .req_wdata (data_sram_wdata),
      .awready   (axi.awready),
      .wready    (axi.wready),
      .bvalid    (axi.bvalid),
      .awaddr    (awaddr),
      .awsize    (awsize),
      .awvalid   (awvalid),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wvalid    (wvalid),
      .aw_w_done (aw_w_done),
      .wr_done   (wr_done)
   );
endmodule
